// File: rtl/onchip_loader_pkg.sv
// ----------------------------------------------------------------------------
// onchip_loader_pkg
//  Shared types and constants for the on-chip RAM byte loader.
//  Contents: loader FSM state enum, default ADDR_W/LEN_W, lane count, and a
//  helper that builds the byte-enable mask of the final (possibly partial) word.
//  Optional feature macro used by the loader: ONCHIP_LOADER_VERIFY_EN.
// ----------------------------------------------------------------------------
package onchip_loader_pkg;

    localparam int ADDR_W_DEF     = 15;
    localparam int LEN_W_DEF      = 18;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        VRD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Lanes occupied by the last word of an image whose length mod 4 is n.
    function automatic logic [BYTES_PER_WORD-1:0] tail_be(input logic [1:0] n);
        case (n)
            2'd1:    tail_be = 4'b0001;
            2'd2:    tail_be = 4'b0011;
            2'd3:    tail_be = 4'b0111;
            default: tail_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/onchip_mem_byte_loader_if.sv
// ----------------------------------------------------------------------------
// onchip_mem_byte_loader_if
//  Bundles the loader's byte stream (valid/ready) and the Avalon-style RAM
//  port (s1) into one interface.
//  master : loader side  - takes s_data/s_valid/mem_readdata, drives the rest
//  slave  : env side     - byte source plus RAM
// ----------------------------------------------------------------------------
interface onchip_mem_byte_loader_if #(
    parameter int ADDR_W = 15
) ();
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  s_data, s_valid, mem_readdata,
        output s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output s_data, s_valid, mem_readdata,
        input  s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_loader_packer.sv
// ----------------------------------------------------------------------------
// onchip_loader_packer
//  Packs accepted stream bytes little-endian into a 32-bit word, tracking the
//  filled lanes as a byte-enable mask.
//  Ports:
//   clk, reset   clock / async active-high reset
//   i_accept     byte handshake this cycle
//   i_data       byte being accepted
//   i_last       accepted byte is the last of the image
//   i_clear      word has been written; restart at lane 0 with no lanes set
//   o_word       packed word
//   o_be         filled lanes
//   o_flush      this byte completes a word (lane 3) or ends the image
// ----------------------------------------------------------------------------
module onchip_loader_packer
    import onchip_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_accept,
    input  logic [7:0]                    i_data,
    input  logic                          i_last,
    input  logic                          i_clear,
    output logic [BYTES_PER_WORD*8-1:0]   o_word,
    output logic [BYTES_PER_WORD-1:0]     o_be,
    output logic                          o_flush
);

    logic [1:0]                          r_lane;
    logic [BYTES_PER_WORD-1:0][7:0]      r_word;
    logic [BYTES_PER_WORD-1:0]           r_be;
    logic [BYTES_PER_WORD-1:0]           w_hit;

    genvar k;
    generate
        for (k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
            assign w_hit[k] = i_accept && (r_lane == 2'(k));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
            r_be   <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_be   <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (w_hit[i]) begin
                    r_word[i] <= i_data;
                    r_be[i]   <= 1'b1;
                end
            end
        end
    end

    assign o_word  = r_word;
    assign o_be    = r_be;
    assign o_flush = i_accept && ((r_lane == 2'd3) || i_last);

endmodule

// File: rtl/onchip_mem_byte_loader.sv
// ----------------------------------------------------------------------------
// onchip_mem_byte_loader
//  Write-side feeder for the 32K x 32 on-chip RAM. Takes a byte stream, packs
//  it into words with byte enables and writes them from a programmed base
//  word address (address wraps modulo 2^ADDR_W).
//  Ports:
//   clk, reset         clock / async active-high reset
//   start              pulse in IDLE: latch base_addr/byte_len and begin
//   base_addr          first RAM word address
//   byte_len           bytes to load (0 = done next cycle, no RAM access)
//   bus (master)       byte stream + RAM port, see onchip_mem_byte_loader_if
//   busy               high from accepted start until done
//   done               one-cycle end-of-load pulse
//   verify_err         sticky readback mismatch, cleared on start
//  Macro ONCHIP_LOADER_VERIFY_EN: after the last write, re-read all written
//  words, sum their enabled lanes and compare with the sum of loaded bytes.
// ----------------------------------------------------------------------------
module onchip_mem_byte_loader
    import onchip_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LEN_W-1:0]          byte_len,
    onchip_mem_byte_loader_if.master  bus,
    output logic                      busy,
    output logic                      done,
    output logic                      verify_err
);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rem;
    logic                w_accept;
    logic                w_flush;
    logic [31:0]         w_pk_word;
    logic [3:0]          w_pk_be;
    logic                w_start;

    assign w_start  = (r_state == IDLE) && start;
    assign w_accept = bus.s_valid && (r_state == LOAD);

    onchip_loader_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .i_accept (w_accept),
        .i_data   (bus.s_data),
        .i_last   (r_rem == LEN_W'(1)),
        .i_clear  (r_state == WRITE),
        .o_word   (w_pk_word),
        .o_be     (w_pk_be),
        .o_flush  (w_flush)
    );

`ifdef ONCHIP_LOADER_VERIFY_EN
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W:0]     r_words;     // words written so far
    logic [ADDR_W:0]     r_left;      // readback addresses still to issue
    logic [3:0]          r_tail_be;
    logic [31:0]         r_sum;
    logic [31:0]         r_rsum;
    logic                r_rd_vld;    // mem_readdata holds a requested word
    logic                r_rd_last;
    logic                r_verr;
    logic                w_issue;
    logic [3:0]          w_rd_mask;
    logic [31:0]         w_rd_term;
    logic [31:0]         w_rsum_nxt;

    assign w_issue = (r_state == VRD) && (r_left != '0);

    always_comb begin
        w_rd_mask = r_rd_last ? r_tail_be : 4'hF;
        w_rd_term = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (w_rd_mask[i]) w_rd_term = w_rd_term + {24'h0, bus.mem_readdata[8*i +: 8]};
        end
        w_rsum_nxt = r_rsum + w_rd_term;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base    <= '0;
            r_raddr   <= '0;
            r_words   <= '0;
            r_left    <= '0;
            r_tail_be <= '0;
            r_sum     <= '0;
            r_rsum    <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_verr    <= 1'b0;
        end else begin
            if (w_start) begin
                r_base    <= base_addr;
                r_words   <= '0;
                r_tail_be <= tail_be(byte_len[1:0]);
                r_sum     <= '0;
                r_verr    <= 1'b0;
            end
            if (w_accept) r_sum <= r_sum + {24'h0, bus.s_data};
            if (r_state == WRITE) begin
                r_words <= r_words + 1'b1;
                if (r_rem == '0) begin
                    r_raddr <= r_base;
                    r_left  <= r_words + 1'b1;   // include the word written now
                    r_rsum  <= '0;
                end
            end
            if (w_issue) begin
                r_raddr <= r_raddr + 1'b1;
                r_left  <= r_left - 1'b1;
            end
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && (r_left == (ADDR_W+1)'(1));
            if (r_rd_vld) begin
                r_rsum <= w_rsum_nxt;
                if (r_rd_last && (w_rsum_nxt != r_sum)) r_verr <= 1'b1;
            end
        end
    end

    assign verify_err = r_verr;
`else
    logic [31:0] w_unused_rd;
    assign w_unused_rd = bus.mem_readdata;
    assign verify_err  = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (start) w_state_nxt = (byte_len == '0) ? DONE : LOAD;
            LOAD:  if (w_flush) w_state_nxt = WRITE;
            WRITE: begin
                if (r_rem != '0) w_state_nxt = LOAD;
`ifdef ONCHIP_LOADER_VERIFY_EN
                else             w_state_nxt = VRD;
`else
                else             w_state_nxt = DONE;
`endif
            end
`ifdef ONCHIP_LOADER_VERIFY_EN
            VRD:   if (r_rd_vld && r_rd_last) w_state_nxt = DONE;
`endif
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- address / byte count ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else begin
            if (w_start) begin
                r_addr <= base_addr;
                r_rem  <= byte_len;
            end
            if (w_accept && (r_rem != '0)) r_rem <= r_rem - 1'b1;
            if (r_state == WRITE)          r_addr <= r_addr + 1'b1;
        end
    end

    // ---------------- bus outputs ----------------
    always_comb begin
        bus.s_ready        = 1'b0;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = r_addr;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        case (r_state)
            LOAD:  bus.s_ready = 1'b1;
            WRITE: begin
                bus.mem_chipselect = 1'b1;
                bus.mem_write      = 1'b1;
                bus.mem_byteenable = w_pk_be;
                bus.mem_writedata  = w_pk_word;
            end
`ifdef ONCHIP_LOADER_VERIFY_EN
            VRD: begin
                bus.mem_address = r_raddr;
                if (w_issue) begin
                    bus.mem_chipselect = 1'b1;
                    bus.mem_byteenable = 4'hF;
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.mem_clken = 1'b1;
    assign busy = (r_state != IDLE) && (r_state != DONE);
    assign done = (r_state == DONE);

endmodule
